// File: rtl/prog_sequencer.sv
// Program-run controller: arms one of NUM_PROGS entry points on the Start handshake,
// sequences the PC with relative branches until the all-ones halt opcode, and counts run cycles.
module prog_sequencer #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned INST_W    = 9,
  parameter int unsigned TGT_W     = 8,
  parameter int unsigned NUM_PROGS = 3,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = {10'd512, 10'd256, 10'd0},
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        prog_sel_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              branch_en_i,
  input  logic              forward_i,
  input  logic [TGT_W-1:0]  target_i,
  output logic [PC_W-1:0]   prog_ctr_o,
  output logic              going_o,
  output logic              ack_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [2:0]        active_prog_o,
  output logic              sel_err_o
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       active_q;
  logic             sel_err_q;
  logic             going_q;
  logic             ack_q;

  logic [3:0]       num_progs_c;
  logic             sel_valid;
  logic [PC_W-1:0]  sel_base;
  logic [PC_W-1:0]  tgt_ext;
  logic [PC_W-1:0]  pc_run;
  logic             halt;

  assign num_progs_c = 4'(NUM_PROGS);
  assign sel_valid   = {1'b0, prog_sel_i} < num_progs_c;
  assign tgt_ext     = PC_W'(target_i);
  assign halt        = (inst_i == {INST_W{1'b1}});

  // Slot lookup only matches in-range indices, so PROG_BASE is never indexed out of bounds.
  always_comb begin
    sel_base = '0;
    for (int k = 0; k < int'(NUM_PROGS); k++) begin
      if (prog_sel_i == 3'(k)) sel_base = PROG_BASE[k*PC_W +: PC_W];
    end
  end

  always_comb begin
    pc_run = pc_q + PC_W'(1);
    if (branch_en_i) pc_run = forward_i ? (pc_q + tgt_ext) : (pc_q - tgt_ext);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      sel_err_q <= 1'b0;
      going_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            if (sel_valid) begin
              state_q  <= StArm;
              pc_q     <= sel_base;
              active_q <= prog_sel_i;
              going_q  <= 1'b0;
              ack_q    <= 1'b0;
            end else begin
              sel_err_q <= 1'b1;
            end
          end
        end
        StArm: begin
          if (start_i) begin
            if (sel_valid) begin
              pc_q     <= sel_base;
              active_q <= prog_sel_i;
            end else begin
              sel_err_q <= 1'b1;
            end
          end else begin
            state_q <= StRun;
            cnt_q   <= '0;
            going_q <= 1'b1;
          end
        end
        StRun: begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
          // Halt wins over a simultaneous branch; PC stays on the halt address.
          if (halt) begin
            state_q <= StDone;
            going_q <= 1'b0;
            ack_q   <= 1'b1;
          end else begin
            pc_q <= pc_run;
          end
        end
        default: begin
          state_q <= StIdle;
          going_q <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr_o    = pc_q;
  assign going_o       = going_q;
  assign ack_o         = ack_q;
  assign cycle_count_o = cnt_q;
  assign active_prog_o = active_q;
  assign sel_err_o     = sel_err_q;

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Parametrised program-run controller replacing the fixed program counter and start/ack glue inside the processor top level. It holds up to NUM_PROGS program entry points and arms the selected one on the Start handshake. It sequences the PC with relative forward/backward branches, detects the all-ones halt instruction and raises Ack. It also keeps a saturating per-run cycle count. Instruction ROM, Ctrl and datapath sit around it unchanged: ROM data feeds InstIn, Ctrl drives BranchEn, and RegFile drives Target.

## Interface
- PC_W, 10: program counter width; instruction ROM depth is 2^PC_W.
- INST_W, 9: instruction width; the halt opcode is all ones of this width.
- TGT_W, 8: branch distance width, zero-extended to PC_W.
- NUM_PROGS, 3: number of program slots, 1..8.
- PROG_BASE, {10'd512,10'd256,10'd0}: packed NUM_PROGS*PC_W entry addresses; slot k is bits [k*PC_W +: PC_W].
- CNT_W, 16: cycle counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level request; the program starts when Start falls.
- ProgSel  in  3  slot index, sampled while Start is high.
- InstIn  in  INST_W  instruction at ProgCtr, combinational from ROM.
- BranchEn  in  1  take branch this cycle; honoured only in RUN.
- forward  in  1  1 means PC+Target, 0 means PC-Target.
- Target  in  TGT_W  branch distance.
- ProgCtr  out  PC_W  registered PC.
- Going  out  1  high only in RUN.
- Ack  out  1  high only in DONE.
- CycleCount  out  CNT_W  cycles of the current or last run.
- ActiveProg  out  3  slot of the current or last run.
- SelErr  out  1  sticky flag: Start was seen with ProgSel >= NUM_PROGS.

## Operation
States are IDLE, ARM, RUN and DONE.

- **IDLE**
  - Start=1 with a valid ProgSel: go to ARM, set ProgCtr to PROG_BASE[ProgSel], latch ActiveProg.
  - Start=1 with an invalid ProgSel: stay in IDLE, set SelErr.
- **ARM**
  - Start=1: re-sample ProgSel each cycle and reload ProgCtr and ActiveProg. An invalid ProgSel sets SelErr and leaves the previous valid selection in place.
  - Start=0: go to RUN and clear CycleCount to 0.
- **RUN**
  - InstIn is all ones (halt): go to DONE; ProgCtr is not updated. The halt check takes priority over BranchEn.
  - Otherwise, BranchEn=1: ProgCtr <= ProgCtr ± zero-extended Target, modulo 2^PC_W.
  - Otherwise: ProgCtr <= ProgCtr+1, wrapping from 2^PC_W-1 to 0.
  - Start is ignored in RUN.
- **DONE**
  - ProgCtr, CycleCount and ActiveProg hold.
  - Start=1 behaves as in IDLE (valid ProgSel goes to ARM), which allows back-to-back programs.
- **CycleCount**
  - Increments on every RUN clock edge, including the edge that leaves RUN on halt.
  - Saturates at 2^CNT_W-1.
- **SelErr** is cleared only by Reset.
- ProgSel values of 3 bits and NUM_PROGS up to 8 are covered; out-of-range slot values never index PROG_BASE.

## Timing
- Reset (asynchronous, independent of Clk) forces:
  - state IDLE
  - ProgCtr=0
  - Going=0
  - Ack=0
  - CycleCount=0
  - ActiveProg=0
  - SelErr=0
- Reset asserted mid-run aborts immediately; there is no resumption.
- Going and Ack are decoded from registered state, so there is no combinational path from the inputs.
- Start falling to Going=1 takes 1 cycle: the first RUN cycle fetches PROG_BASE[sel].
- One instruction per cycle in RUN: a taken branch's target is on ProgCtr on the next edge.
- Halt fetched in cycle n gives Ack=1 from edge n+1; ProgCtr stays on the halt address.
- Run of N non-halt instructions followed by halt: CycleCount = N+1 in DONE.
- ROM read is combinational, so InstIn is valid in the same cycle as ProgCtr.

## Test plan
- Reset mid-run: assert Reset while in RUN at ProgCtr=37 -> immediately ProgCtr=0, Going=0, Ack=0, CycleCount=0, without waiting for a Clk edge.
- Basic run: Start high 2 cycles with ProgSel=1, then low; ROM at 256..259 holds non-halt instructions, 260 holds 9'h1FF -> Going for 5 cycles, Ack=1 with ProgCtr=260, CycleCount=5, ActiveProg=1.
- Branches: at PC=300 apply BranchEn=1, forward=0, Target=8 -> PC=292; at PC=1020 apply forward=1, Target=10 -> PC=6 (wrap). Halt and BranchEn together at PC=50 -> DONE, PC stays 50.
- Invalid select and re-arm:
  - ProgSel=5 with NUM_PROGS=3 -> stays IDLE, SelErr=1.
  - Then ProgSel=2 -> runs from 512, SelErr still 1.
  - From DONE, Start with ProgSel=0 -> ARM, ProgCtr=0, CycleCount restarts at 0.
- Saturation: CNT_W=4, 20 non-halt cycles -> CycleCount holds at 15 and does not wrap.
